slot_decoder: RTL

Parametrised Apple II-style peripheral-slot decoder for the IIgs core. It replaces the hard-wired slot-7 DEVSEL/IOSEL logic in the system top with per-slot DEVICE SELECT, I/O SELECT and I/O STROBE for slots 1..NUM_SLOTS, gated by SLTROMSEL. It tracks ownership of the shared $C800–$CFFF expansion-ROM window and returns the selected card's read data to the CPU data mux. It sits between the CPU address bus and the card models (hdd and future cards).

---
 rtl/slot_pkg.sv | 21 ++
 rtl/slot_addr_decode.sv | 28 ++
 rtl/slot_decoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared constants, address classes and helpers for the peripheral-slot decoder.
package slot_pkg;

  localparam logic [15:0] DEVSEL_BASE = 16'hC080;
  localparam logic [15:0] IOSEL_BASE  = 16'hC100;
  localparam logic [15:0] STROBE_BASE = 16'hC800;
  localparam logic [15:0] CFFF_ADDR   = 16'hCFFF;

  typedef enum logic [2:0] {NONE, DEVSEL, IOSEL, STROBE, CLEAR} addr_cls_e;

  // Banks 00/01/E0/E1 are the only banks that see the slot I/O space.
  function automatic logic io_bank(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'h01) || (b == 8'hE0) || (b == 8'hE1);
  endfunction

  // $C0n0 soft switches carry the slot in addr[6:4]; $Cs00 pages carry it in addr[10:8].
  function automatic logic [2:0] slot_of(input logic [15:0] a);
    return (a[15:8] == 8'hC0) ? a[6:4] : a[10:8];
  endfunction

endpackage

// File: rtl/slot_addr_decode.sv
// Combinational classifier: maps a CPU bank/address to a slot address class and slot number.
module slot_addr_decode
  import slot_pkg::*;
(
  input  logic [7:0]  bank_i,
  input  logic [15:0] addr_i,
  output addr_cls_e   cls_o,
  output logic [2:0]  slot_o,
  output logic        qual_o
);

  always_comb begin
    qual_o = io_bank(bank_i);
    slot_o = slot_of(addr_i);
    cls_o  = NONE;
    if (qual_o) begin
      if (addr_i[15:7] == DEVSEL_BASE[15:7])
        cls_o = DEVSEL;
      else if (addr_i >= IOSEL_BASE && addr_i < STROBE_BASE)
        cls_o = IOSEL;
      else if (addr_i == CFFF_ADDR)
        cls_o = CLEAR;
      else if (addr_i[15:11] == STROBE_BASE[15:11])
        cls_o = STROBE;
    end
  end

endmodule

// File: rtl/slot_decoder.sv
// Per-slot DEVSEL/IOSEL/IOSTROBE decode, $C800 window ownership and card read-data mux.
module slot_decoder
  import slot_pkg::*;
#(
  parameter int NUM_SLOTS = 7,
  parameter int DW        = 8
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    phi0,
  input  logic [7:0]              bank,
  input  logic [15:0]             addr,
  input  logic                    we,
  input  logic [7:0]              sltromsel,
  input  logic [NUM_SLOTS*DW-1:0] slot_dout,
  output logic [NUM_SLOTS-1:0]    device_select,
  output logic [NUM_SLOTS-1:0]    io_select,
  output logic [NUM_SLOTS-1:0]    io_strobe,
  output logic                    int_rom_hit,
  output logic                    slot_hit,
  output logic [DW-1:0]           slot_rdata,
  output logic [2:0]              c8_owner
);

  addr_cls_e  cls;
  logic [2:0] slot;
  logic       qual;

  slot_addr_decode u_dec (
    .bank_i (bank),
    .addr_i (addr),
    .cls_o  (cls),
    .slot_o (slot),
    .qual_o (qual)
  );

  logic [NUM_SLOTS-1:0] dev_q, dev_d, ios_q, ios_d, str_q, str_d;
  logic                 rom_q, rom_d, we_q, we_d;
  logic [2:0]           owner_q, owner_d;

  // Next state is a full bus-cycle decode; it is only committed on the phi0 edge.
  always_comb begin
    dev_d   = '0;
    ios_d   = '0;
    str_d   = '0;
    rom_d   = 1'b0;
    we_d    = we;
    owner_d = owner_q;
    unique case (cls)
      DEVSEL: begin
        for (int s = 1; s <= NUM_SLOTS; s++)
          if (slot == 3'(s) && sltromsel[s]) dev_d[s-1] = 1'b1;
      end
      IOSEL: begin
        if (!sltromsel[slot]) rom_d = 1'b1;
        else
          for (int s = 1; s <= NUM_SLOTS; s++)
            if (slot == 3'(s)) begin
              ios_d[s-1] = 1'b1;
              owner_d    = slot;
            end
      end
      STROBE, CLEAR: begin
        for (int s = 1; s <= NUM_SLOTS; s++)
          if (owner_q == 3'(s)) str_d[s-1] = 1'b1;
        if (owner_q == 3'd0 && cls == STROBE) rom_d = 1'b1;
        // $CFFF still strobes the current owner, then releases the window.
        if (cls == CLEAR) owner_d = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dev_q   <= '0;
      ios_q   <= '0;
      str_q   <= '0;
      rom_q   <= 1'b0;
      we_q    <= 1'b0;
      owner_q <= 3'd0;
    end else if (phi0) begin
      dev_q   <= dev_d;
      ios_q   <= ios_d;
      str_q   <= str_d;
      rom_q   <= rom_d;
      we_q    <= we_d;
      owner_q <= owner_d;
    end
  end

  logic [NUM_SLOTS-1:0]         sel;
  logic [NUM_SLOTS-1:0][DW-1:0] lane_data;

  assign sel = dev_q | ios_q | str_q;

  // Selects are one-hot, so an AND-OR mux is sufficient.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    assign lane_data[i] = slot_dout[i*DW +: DW] & {DW{sel[i]}};
  end

  always_comb begin
    slot_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) slot_rdata = slot_rdata | lane_data[i];
  end

  assign device_select = dev_q;
  assign io_select     = ios_q;
  assign io_strobe     = str_q;
  assign int_rom_hit   = rom_q;
  assign c8_owner      = owner_q;
  assign slot_hit      = (|sel) & ~we_q;

endmodule
